// File: rtl/pc_seq_pkg.sv
// Shared control-signal definitions for the fetch front end: jump/branch
// type codes, the PC sequencer state encoding and its address defaults.
package pc_seq_pkg;

  // Jump/branch type codes decoded by the control unit.
  typedef enum logic [2:0] {
    JT_NONE   = 3'd0,
    JT_BRANCH = 3'd1,
    JT_J      = 3'd2,
    JT_JAL    = 3'd3,
    JT_JR     = 3'd4
  } jump_type_e;

  // PC sequencer FSM states; the encoding is visible on the state port.
  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10,
    ST_EXC  = 2'b11
  } pc_state_e;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] PC_EXC_DEFAULT   = 32'h0000_4180;

  // Word-align an address by clearing the byte-offset bits.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_seq_pc_reg.sv
// pc_reg: W-bit register with asynchronous active-high reset to RST_VAL,
// load enable and data input.
module pc_reg #(
  parameter int          W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Hold the value unless loading; reset takes effect immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pc_seq.sv
// pc_seq: program-counter sequencer with BOOT/RUN/HALT/EXC control.
// Optional macro PC_SEQ_EXC_EN enables exception entry (exc_req or a
// misaligned npc) and the epc output; without it the EXC state is never
// entered, exc_req is ignored and misaligned npc bits are dropped.
//
// Handshake: there is no valid/ready pairing here. pc_valid is a
// registered qualifier: when high, pc holds a fetchable instruction address
// for the whole cycle. stall/halt_req/resume/exc_req are level-sensitive and
// sampled on every rising edge in the states where they matter.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = PC_RESET_DEFAULT,
  parameter logic [31:0] EXC_VEC  = PC_EXC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic [31:0] normal_npc,
  input  logic        stall,
  input  logic        halt_req,
  input  logic        resume,
  input  logic        exc_req,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        halted,
  output logic [1:0]  state,
  output logic [31:0] retired
`ifdef PC_SEQ_EXC_EN
  ,
  output logic [31:0] epc
`endif
);

  pc_state_e   st;
  logic        exc_hit;
  logic        misalign;
  logic        advance;
  logic        pc_load;
  logic [31:0] pc_next;

`ifdef PC_SEQ_EXC_EN
  assign exc_hit  = exc_req;
  assign misalign = |npc[1:0];
`else
  logic unused_inputs;
  assign unused_inputs = ^{exc_req, npc[1:0]};
  assign exc_hit  = 1'b0;
  assign misalign = 1'b0;
`endif

  // A RUN cycle with no higher-priority request moves to npc.
  assign advance = (st == ST_RUN) && !exc_hit && !halt_req && !stall;
  assign state   = st;

  // Select whether and what the PC register loads this cycle.
  always_comb begin
    pc_load = 1'b0;
    pc_next = word_align(npc);
    case (st)
      ST_RUN:  pc_load = advance && !misalign;
      ST_HALT: begin
        pc_load = resume;
        pc_next = normal_npc;
      end
      ST_EXC: begin
        pc_load = 1'b1;
        pc_next = EXC_VEC;
      end
      default: pc_load = 1'b0;
    endcase
  end

  pc_reg #(
    .W       (32),
    .RST_VAL (RESET_PC)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (pc_load),
    .d   (pc_next),
    .q   (pc)
  );

  // Control FSM with registered status outputs and the retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= ST_BOOT;
      retired  <= '0;
      pc_valid <= 1'b0;
      halted   <= 1'b0;
`ifdef PC_SEQ_EXC_EN
      epc      <= '0;
`endif
    end else begin
      case (st)
        ST_BOOT: begin
          st       <= ST_RUN;
          pc_valid <= 1'b1;
        end
        ST_RUN: begin
          if (exc_hit || (advance && misalign)) begin
            st       <= ST_EXC;
            pc_valid <= 1'b0;
          end else if (halt_req) begin
            st       <= ST_HALT;
            pc_valid <= 1'b0;
            halted   <= 1'b1;
          end else if (advance) begin
            // Counter wraps naturally at 32 bits.
            retired <= retired + 32'd1;
          end
        end
        ST_HALT: begin
          if (resume) begin
            st       <= ST_RUN;
            pc_valid <= 1'b1;
            halted   <= 1'b0;
            retired  <= retired + 32'd1;
          end
        end
        ST_EXC: begin
`ifdef PC_SEQ_EXC_EN
          epc      <= pc;
`endif
          st       <= ST_RUN;
          pc_valid <= 1'b1;
        end
        default: begin
          st       <= ST_BOOT;
          pc_valid <= 1'b0;
          halted   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// Testbench for pc_seq: directed scenarios plus a randomized run checked
// against a rule-level reference model. Follows PC_SEQ_EXC_EN if defined.
module tb_pc_seq;

`ifdef PC_SEQ_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] npc, normal_npc;
  logic        stall, halt_req, resume, exc_req;
  logic [31:0] pc, retired;
  logic        pc_valid, halted;
  logic [1:0]  state;
`ifdef PC_SEQ_EXC_EN
  logic [31:0] epc;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: mode 0=BOOT 1=RUN 2=HALT 3=EXC as numbered by the spec.
  int          m_mode;
  logic [31:0] m_pc, m_ret, m_epc;

  // clock
  always #5 clk = ~clk;

  pc_seq dut (
    .clk        (clk),
    .rst        (rst),
    .npc        (npc),
    .normal_npc (normal_npc),
    .stall      (stall),
    .halt_req   (halt_req),
    .resume     (resume),
    .exc_req    (exc_req),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .halted     (halted),
    .state      (state),
    .retired    (retired)
`ifdef PC_SEQ_EXC_EN
    ,
    .epc        (epc)
`endif
  );

  task automatic model_reset();
    m_mode = 0;
    m_pc   = 32'h0000_3000;
    m_ret  = 0;
    m_epc  = 0;
  endtask

  // One clock of the spec's rules, evaluated on the inputs present at the edge.
  task automatic model_step();
    case (m_mode)
      0: m_mode = 1;
      1: begin
        if (EXC_EN && exc_req) m_mode = 3;
        else if (halt_req) m_mode = 2;
        else if (!stall) begin
          if (EXC_EN && (npc % 4 != 0)) m_mode = 3;
          else begin
            m_pc  = npc - (npc % 4);
            m_ret = m_ret + 1;
          end
        end
      end
      2: if (resume) begin
        m_pc   = normal_npc;
        m_ret  = m_ret + 1;
        m_mode = 1;
      end
      default: begin
        m_epc  = m_pc;
        m_pc   = 32'h0000_4180;
        m_mode = 1;
      end
    endcase
  endtask

  // Advance one rising edge, update the model, then settle 1ns past the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic clear_inputs();
    npc = 32'h0; normal_npc = 32'h0;
    stall = 0; halt_req = 0; resume = 0; exc_req = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    tick();
    n_tests++;
    if (pc !== 32'h3000 || state !== 2'b00 || pc_valid !== 1'b0 || halted !== 1'b0 || retired !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_hold: pc=%h state=%b valid=%b halted=%b retired=%0d, expected pc=3000 state=00 valid=0 halted=0 retired=0",
               pc, state, pc_valid, halted, retired);
    end
    rst = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if (state !== 2'b00 || pc !== 32'h3000 || pc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_cycle1: state=%b pc=%h valid=%b, expected 00 3000 0", state, pc, pc_valid);
    end
    tick();
    n_tests++;
    if (state !== 2'b01 || pc !== 32'h3000 || pc_valid !== 1'b1 || retired !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_cycle2: state=%b pc=%h valid=%b retired=%0d, expected 01 3000 1 0", state, pc, pc_valid, retired);
    end
  endtask

  task automatic test_advance();
    npc = 32'h3004;
    tick();
    n_tests++;
    if (pc !== 32'h3004 || retired !== 32'd1) begin
      n_fail++;
      $display("FAIL advance_1: pc=%h retired=%0d, expected 3004 1", pc, retired);
    end
    npc = 32'h3010;
    tick();
    n_tests++;
    if (pc !== 32'h3010 || retired !== 32'd2 || pc_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL advance_2: pc=%h retired=%0d valid=%b, expected 3010 2 1", pc, retired, pc_valid);
    end
  endtask

  task automatic test_stall();
    npc = 32'h3008;
    tick();
    stall = 1'b1;
    npc   = 32'h3050;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (pc !== 32'h3008 || retired !== 32'd3 || pc_valid !== 1'b1 || state !== 2'b01) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: pc=%h retired=%0d valid=%b state=%b, expected 3008 3 1 01",
                 i, pc, retired, pc_valid, state);
      end
    end
    stall = 1'b0;
    npc   = 32'h300c;
    tick();
    n_tests++;
    if (pc !== 32'h300c || retired !== 32'd4) begin
      n_fail++;
      $display("FAIL stall_release: pc=%h retired=%0d, expected 300c 4", pc, retired);
    end
  endtask

  task automatic test_halt();
    npc = 32'h3020;
    tick();
    halt_req = 1'b1;
    tick();
    n_tests++;
    if (state !== 2'b10 || halted !== 1'b1 || pc_valid !== 1'b0 || pc !== 32'h3020 || retired !== 32'd5) begin
      n_fail++;
      $display("FAIL halt_enter: state=%b halted=%b valid=%b pc=%h retired=%0d, expected 10 1 0 3020 5",
               state, halted, pc_valid, pc, retired);
    end
    // stall and halt_req toggling inside HALT must have no effect
    for (int i = 0; i < 5; i++) begin
      halt_req = 1'($urandom_range(0, 1));
      stall    = 1'($urandom_range(0, 1));
      npc      = $urandom;
      tick();
      n_tests++;
      if (state !== 2'b10 || halted !== 1'b1 || pc_valid !== 1'b0 || pc !== 32'h3020 || retired !== 32'd5) begin
        n_fail++;
        $display("FAIL halt_hold[%0d]: state=%b halted=%b valid=%b pc=%h retired=%0d, expected 10 1 0 3020 5",
                 i, state, halted, pc_valid, pc, retired);
      end
    end
    halt_req   = 1'b0;
    stall      = 1'b0;
    resume     = 1'b1;
    normal_npc = 32'h3024;
    tick();
    resume = 1'b0;
    n_tests++;
    if (state !== 2'b01 || halted !== 1'b0 || pc_valid !== 1'b1 || pc !== 32'h3024 || retired !== 32'd6) begin
      n_fail++;
      $display("FAIL halt_resume: state=%b halted=%b valid=%b pc=%h retired=%0d, expected 01 0 1 3024 6",
               state, halted, pc_valid, pc, retired);
    end
  endtask

`ifdef PC_SEQ_EXC_EN
  task automatic test_exc();
    npc = 32'h3040;
    tick();
    exc_req  = 1'b1;
    halt_req = 1'b1;
    tick();
    exc_req  = 1'b0;
    halt_req = 1'b0;
    n_tests++;
    if (state !== 2'b11 || pc_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL exc_enter: state=%b valid=%b halted=%b, expected 11 0 0", state, pc_valid, halted);
    end
    tick();
    n_tests++;
    if (state !== 2'b01 || epc !== 32'h3040 || pc !== 32'h4180 || pc_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL exc_vector: state=%b epc=%h pc=%h valid=%b, expected 01 3040 4180 1", state, epc, pc, pc_valid);
    end
    npc = 32'h3046;
    tick();
    n_tests++;
    if (state !== 2'b11 || pc_valid !== 1'b0 || retired !== 32'd7) begin
      n_fail++;
      $display("FAIL exc_misalign: state=%b valid=%b retired=%0d, expected 11 0 7", state, pc_valid, retired);
    end
    tick();
    n_tests++;
    if (state !== 2'b01 || epc !== 32'h4180 || pc !== 32'h4180) begin
      n_fail++;
      $display("FAIL exc_misalign_exit: state=%b epc=%h pc=%h, expected 01 4180 4180", state, epc, pc);
    end
  endtask
`else
  task automatic test_exc_ignored();
    exc_req = 1'b1;
    npc     = 32'h3046;
    tick();
    exc_req = 1'b0;
    n_tests++;
    if (state !== 2'b01 || pc !== 32'h3044 || pc_valid !== 1'b1 || retired !== 32'd7) begin
      n_fail++;
      $display("FAIL exc_ignored: state=%b pc=%h valid=%b retired=%0d, expected 01 3044 1 7", state, pc, pc_valid, retired);
    end
  endtask
`endif

  task automatic test_rst_mid_halt();
    do_reset();
    tick();
    for (int i = 0; i < 7; i++) begin
      npc = m_pc + 32'(4 * $urandom_range(1, 16));
      tick();
    end
    npc      = 32'h0;
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    n_tests++;
    if (state !== 2'b10 || retired !== 32'd7 || pc !== m_pc) begin
      n_fail++;
      $display("FAIL pre_rst_halt: state=%b retired=%0d pc=%h, expected 10 7 %h", state, retired, pc, m_pc);
    end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (state !== 2'b00 || pc !== 32'h3000 || retired !== 32'd0 || halted !== 1'b0 || pc_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: state=%b pc=%h retired=%0d halted=%b valid=%b, expected 00 3000 0 0 0",
               state, pc, retired, halted, pc_valid);
    end
    model_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      stall      = ($urandom_range(0, 3) == 0);
      halt_req   = ($urandom_range(0, 9) == 0);
      resume     = ($urandom_range(0, 2) == 0);
      exc_req    = ($urandom_range(0, 15) == 0);
      normal_npc = m_pc + 32'd4;
      npc        = m_pc + 32'(4 * $urandom_range(0, 64)) +
                   (($urandom_range(0, 7) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      tick();
      n_tests++;
      if (pc !== m_pc || retired !== m_ret || state !== 2'(m_mode) ||
          pc_valid !== (m_mode == 1) || halted !== (m_mode == 2)) begin
        n_fail++;
        $display("FAIL random[%0d]: pc=%h retired=%0d state=%b valid=%b halted=%b, expected pc=%h retired=%0d state=%0d valid=%0d halted=%0d",
                 i, pc, retired, state, pc_valid, halted, m_pc, m_ret, m_mode, (m_mode == 1), (m_mode == 2));
      end
`ifdef PC_SEQ_EXC_EN
      n_tests++;
      if (epc !== m_epc) begin
        n_fail++;
        $display("FAIL random_epc[%0d]: epc=%h expected %h", i, epc, m_epc);
      end
`endif
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_advance();
    test_stall();
    test_halt();
`ifdef PC_SEQ_EXC_EN
    test_exc();
`else
    test_exc_ignored();
`endif
    test_rst_mid_halt();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000: PC loaded at reset.
REQ-002 SHALL have parameter EXC_VEC, default 32'h0000_4180: exception vector (used only under PC_SEQ_EXC_EN).
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port npc, input, 32: next PC from the next-PC datapath, combinational on pc.
REQ-006 SHALL have port normal_npc, input, 32: pc+4 from the next-PC datapath.
REQ-007 SHALL have port stall, input, 1: hold the PC this cycle.
REQ-008 SHALL have port halt_req, input, 1: enter HALT (syscall/break).
REQ-009 SHALL have port resume, input, 1: leave HALT.
REQ-010 SHALL have port exc_req, input, 1: external exception request (ignored without PC_SEQ_EXC_EN).
REQ-011 SHALL have port pc, output, 32: current fetch address.
REQ-012 SHALL have port pc_valid, output, 1: pc is a fetchable instruction this cycle.
REQ-013 SHALL have port halted, output, 1: FSM in HALT.
REQ-014 SHALL have port state, output, 2: FSM state encoding.
REQ-015 SHALL have port retired, output, 32: count of cycles in which pc advanced.
REQ-016 SHALL have port epc, output, 32: PC of the excepting instruction (present only under PC_SEQ_EXC_EN).

Function
REQ-017 SHALL implement FSM states BOOT=2'b00, RUN=2'b01, HALT=2'b10, EXC=2'b11.
REQ-018 SHALL leave BOOT unconditionally after one cycle to RUN, with pc=RESET_PC and pc_valid=0 in BOOT.
REQ-019 SHALL, in RUN, apply priority exc_req > halt_req > stall > advance, evaluated each cycle.
REQ-020 SHALL, on advance in RUN, load pc<=npc with pc[1:0] forced to 2'b00 and increment retired by 1.
REQ-021 SHALL, on stall in RUN, hold pc and retired; pc_valid stays 1.
REQ-022 SHALL, on halt_req in RUN, hold pc, go to HALT next cycle; pc_valid=0 and halted=1 while in HALT.
REQ-023 SHALL, in HALT with resume=1, load pc<=normal_npc, increment retired, go to RUN; resume=0 holds HALT.
REQ-024 SHALL ignore stall and halt_req while in HALT or EXC.
REQ-025 SHALL wrap retired from 32'hFFFF_FFFF to 0 without a flag.
REQ-026 SHALL use pc_valid=1 only in RUN.

Reset
REQ-027 SHALL, while rst=1 regardless of clk, force state=BOOT, pc=RESET_PC, retired=0, epc=0, pc_valid=0, halted=0.
REQ-028 SHALL abandon any pending halt, stall or exception on rst mid-operation; no partial update survives.

Configuration
REQ-029 SHALL support macro PC_SEQ_EXC_EN. When defined: exc_req in RUN, or advance with npc[1:0]!=0, enters EXC; in EXC epc<=pc, pc<=EXC_VEC, pc_valid=0, then RUN next cycle. When undefined: EXC state unreachable, exc_req ignored, epc absent, misaligned npc bits silently dropped.

Structure
REQ-030 SHALL place the FSM state encodings and RESET_PC/EXC_VEC defaults in the shared control-signal definitions file alongside the existing jump/branch type defines.
REQ-031 SHALL instantiate one sub-module, pc_reg: 32-bit register with async reset value, load enable and data input.

Verification
REQ-032 Reset release -> cycle 1 state=BOOT pc=32'h3000 pc_valid=0; cycle 2 state=RUN pc_valid=1.
REQ-033 RUN, npc=32'h3004 then 32'h3010 with no stall -> pc 3000,3004,3010; retired=2.
REQ-034 stall=1 for 3 cycles at pc=32'h3008 -> pc holds 3008, retired unchanged; then advances to npc.
REQ-035 halt_req at pc=32'h3020 -> HALT, pc_valid=0 for 5 cycles; resume with normal_npc=32'h3024 -> pc=3024, RUN.
REQ-036 PC_SEQ_EXC_EN: exc_req and halt_req together at pc=32'h3040 -> EXC, epc=32'h3040, pc=32'h4180, then RUN; npc=32'h3046 -> EXC.
REQ-037 rst asserted mid-HALT with retired=7 -> immediately pc=32'h3000, retired=0, state=BOOT.
